// File: rtl/nibbler_trace_pkg.sv
// Shared types and widths for the Nibbler trace buffer.
package nibbler_trace_pkg;

  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;
  localparam int FLAG_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_RING = 2'd0,
    MODE_FILL = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Width of one trace entry {address, program_byte, data_bus, flags}.
  function automatic int entry_w(input int addr_w);
    return addr_w + BYTE_W + NIB_W + FLAG_W;
  endfunction

endpackage

// File: rtl/nibbler_trace_ram.sv
// Trace storage: synchronous write, asynchronous read.
module nibbler_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per write strobe; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nibbler_trace_buffer.sv
// Nibbler CPU trace buffer: captures one entry per phase rise into a ring,
// with continuous, fill-once and address-triggered capture modes.
module nibbler_trace_buffer
  import nibbler_trace_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       phase,
  input  logic [ADDR_W-1:0]          address,
  input  logic [7:0]                 program_byte,
  input  logic [3:0]                 data_bus,
  input  logic [1:0]                 flags,
  input  logic [1:0]                 mode,
  input  logic [ADDR_W-1:0]          trig_addr,
  input  logic                       arm,
  output logic                       rd_valid,
  output logic [ADDR_W+13:0]         rd_data,
  input  logic                       rd_ready,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int EW = entry_w(ADDR_W);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          state_reg, state_next;
  mode_t           mode_reg;
  logic            prev_phase_reg;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_calc;
  logic [CW-1:0]   post_reg;
  logic            overflow_reg;

  logic capture, arm_ok, write_en, pop, full, overwrite, trig_hit;
  logic [EW-1:0] entry;

  assign capture   = phase && !prev_phase_reg;
  assign arm_ok    = arm && (state_reg == IDLE || state_reg == DONE);
  assign write_en  = capture && (state_reg == ARMED || state_reg == RUN);
  assign pop       = (count_reg != '0) && rd_ready;
  assign full      = (count_reg == FULL);
  assign overwrite = write_en && full && !pop;
  assign trig_hit  = write_en && (state_reg == ARMED) && (address == trig_addr);
  assign entry     = {address, program_byte, data_bus, flags};

  assign rd_valid = (count_reg != '0);
  assign state    = state_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

  // Occupancy after this cycle's write/pop; a write into a full ring overwrites.
  always_comb begin
    count_calc = count_reg;
    if (write_en && !pop) begin
      if (!full) count_calc = count_reg + CW'(1);
    end else if (pop && !write_en) begin
      count_calc = count_reg - CW'(1);
    end
  end

  // Next-state logic for the capture FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (arm) state_next = (mode_t'(mode) == MODE_TRIG) ? ARMED : RUN;
      end
      ARMED: begin
        if (trig_hit) state_next = (POST_TRIG == 1) ? DONE : RUN;
      end
      RUN: begin
        if (write_en) begin
          case (mode_reg)
            MODE_TRIG: if (post_reg <= CW'(1)) state_next = DONE;
            MODE_FILL: if (count_calc == FULL) state_next = DONE;
            default:   state_next = RUN;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Pointers, occupancy, post-trigger counter, overflow and phase edge history.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_phase_reg <= 1'b1;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      post_reg       <= '0;
      overflow_reg   <= 1'b0;
      mode_reg       <= MODE_RING;
    end else begin
      prev_phase_reg <= phase;
      if (arm_ok) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        post_reg     <= '0;
        overflow_reg <= 1'b0;
        mode_reg     <= mode_t'(mode);
      end else begin
        if (write_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop || overwrite) rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_calc;
        if (overwrite) overflow_reg <= 1'b1;
        if (trig_hit) begin
          post_reg <= CW'(POST_TRIG - 1);
        end else if (write_en && state_reg == RUN && mode_reg == MODE_TRIG &&
                     post_reg != '0) begin
          post_reg <= post_reg - CW'(1);
        end
      end
    end
  end

  nibbler_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk_in),
    .we    (write_en),
    .waddr (wr_ptr_reg),
    .wdata (entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_nibbler_trace_buffer.sv
// Directed scoreboard bench for nibbler_trace_buffer.
module tb_nibbler_trace_buffer;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 16;
  localparam int EW     = ADDR_W + 14;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              phase = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [7:0]        program_byte = '0;
  logic [3:0]        data_bus = '0;
  logic [1:0]        flags = '0;
  logic [1:0]        mode = '0;
  logic [ADDR_W-1:0] trig_addr = '0;
  logic              arm = 1'b0;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic              rd_ready = 1'b0;
  logic [1:0]        state;
  logic [4:0]        count;
  logic              overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] sb[$];

  nibbler_trace_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .POST_TRIG(8)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .phase        (phase),
    .address      (address),
    .program_byte (program_byte),
    .data_bus     (data_bus),
    .flags        (flags),
    .mode         (mode),
    .trig_addr    (trig_addr),
    .arm          (arm),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .state        (state),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int a);
    logic [ADDR_W-1:0] ad;
    logic [7:0] pb;
    ad = ADDR_W'(a);
    pb = 8'((a * 7 + 3) & 8'hFF);
    return {ad, pb, ad[3:0] ^ 4'h5, ad[1:0]};
  endfunction

  // One phase rise carrying the entry for address a.
  task automatic ev(input int a);
    logic [EW-1:0] e;
    e = mk(a);
    phase = 1'b0;
    tick();
    {address, program_byte, data_bus, flags} = e;
    phase = 1'b1;
    tick();
    phase = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    sb.delete();
  endtask

  // Pop one entry and compare it against the scoreboard head.
  task automatic pop_chk(input string tag);
    logic [EW-1:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Fill-once: 16 entries then DONE, read back in order
    do_arm(2'd1);
    chk("fill_run", 32'(state), 32'd2);
    for (int a = 0; a < 16; a++) begin
      ev(a);
      sb.push_back(mk(a));
    end
    tick();
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_done", 32'(state), 32'd3);
    chk("fill_ovf", 32'(overflow), 32'd0);
    for (int a = 0; a < 16; a++) pop_chk("fill_pop");
    chk("fill_empty", 32'(rd_valid), 32'd0);
    ev(99);
    tick();
    chk("done_drop_cnt", 32'(count), 32'd0);
    chk("done_drop_ovf", 32'(overflow), 32'd0);

    // Continuous ring: 20 entries overwrite the 4 oldest
    do_arm(2'd0);
    for (int a = 0; a < 20; a++) begin
      ev(a);
      sb.push_back(mk(a));
      if (sb.size() > DEPTH) void'(sb.pop_front());
    end
    tick();
    chk("ring_count", 32'(count), 32'd16);
    chk("ring_ovf", 32'(overflow), 32'd1);
    chk("ring_state", 32'(state), 32'd2);
    pop_chk("ring_first");

    // Full ring with simultaneous write and pop; arm ignored in RUN
    do_reset();
    do_arm(2'd0);
    for (int a = 100; a < 116; a++) begin
      ev(a);
      sb.push_back(mk(a));
    end
    tick();
    chk("full_count", 32'(count), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd0);
    do_arm(2'd1);
    tick();
    chk("arm_ign_state", 32'(state), 32'd2);
    chk("arm_ign_count", 32'(count), 32'd16);
    chk("arm_ign_data", 32'(rd_data), 32'(sb[0]));
    phase = 1'b0;
    tick();
    {address, program_byte, data_bus, flags} = mk(116);
    phase = 1'b1;
    rd_ready = 1'b1;
    chk("wp_popped", 32'(rd_data), 32'(sb[0]));
    tick();
    phase = 1'b0;
    rd_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(mk(116));
    tick();
    chk("wp_count", 32'(count), 32'd16);
    chk("wp_ovf", 32'(overflow), 32'd0);
    ev(117);
    void'(sb.pop_front());
    sb.push_back(mk(117));
    tick();
    chk("still_ring_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk("wp_drain");

    // Triggered capture: trigger at 0x00A, 7 post-trigger entries
    do_reset();
    trig_addr = 12'h00A;
    do_arm(2'd2);
    chk("trig_armed", 32'(state), 32'd1);
    for (int a = 0; a <= 30; a++) begin
      ev(a);
      if (a <= 17) begin
        sb.push_back(mk(a));
        if (sb.size() > DEPTH) void'(sb.pop_front());
      end
      if (a == 9)  chk("trig_pre", 32'(state), 32'd1);
      if (a == 10) chk("trig_hit", 32'(state), 32'd2);
      if (a == 16) chk("trig_post", 32'(state), 32'd2);
      if (a == 17) chk("trig_done", 32'(state), 32'd3);
    end
    tick();
    chk("trig_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) pop_chk("trig_pop");

    // Reset mid-RUN, phase held high across release
    do_reset();
    do_arm(2'd0);
    for (int a = 40; a < 45; a++) ev(a);
    tick();
    chk("mid_count", 32'(count), 32'd5);
    reset = 1'b1;
    phase = 1'b1;
    rd_ready = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    mode = 2'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    chk("hold_run", 32'(state), 32'd2);
    chk("hold_nocap", 32'(count), 32'd0);
    ev(50);
    sb.push_back(mk(50));
    tick();
    chk("after_cap", 32'(count), 32'd1);
    pop_chk("after_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibbler_trace_buffer.md
NIBBLER_TRACE_BUFFER -- requirements
Module: nibbler_trace_buffer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, CPU address width; DEPTH, default 16, trace entries, power of two >= 2; POST_TRIG, default 8, entries captured from the trigger onward, 1..DEPTH.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk_in  in  1  single clock, all logic on its rising edge
  reset  in  1  synchronous, active-high
  phase  in  1  Nibbler phase signal
  address  in  ADDR_W  CPU program address
  program_byte  in  8  fetched program byte
  data_bus  in  4  CPU data bus
  flags  in  2  CPU carry/zero flags
  mode  in  2  0 continuous ring, 1 fill-once, 2 triggered, 3 reserved (treated as 0)
  trig_addr  in  ADDR_W  trigger address for mode 2
  arm  in  1  single-cycle start pulse
  rd_valid  out  1  entry available at rd_data
  rd_data  out  ADDR_W+14  oldest entry
  rd_ready  in  1  consumer accepts entry
  state  out  2  FSM state encoding
  count  out  clog2(DEPTH)+1  entries held
  overflow  out  1  sticky: an entry was lost or overwritten

Function
REQ-003 A capture event SHALL occur in a cycle where phase is 1 and the registered previous phase is 0; only one event per phase rise.
REQ-004 An entry SHALL pack {address, program_byte, data_bus, flags}, address in the MSBs, all sampled in the capture-event cycle.
REQ-005 FSM states SHALL be IDLE, ARMED, RUN, DONE; state output encoding 0,1,2,3 respectively.
REQ-006 arm in IDLE or DONE SHALL clear count, pointers and overflow, latch mode, and go to ARMED (mode 2) or RUN (modes 0,1,3); arm in ARMED or RUN SHALL be ignored.
REQ-007 In IDLE and DONE capture events SHALL be dropped without setting overflow.
REQ-008 ARMED SHALL write every event into the ring (pre-trigger history); an event with address == trig_addr SHALL be written, load the post counter with POST_TRIG-1, and enter RUN (DONE directly when POST_TRIG = 1).
REQ-009 RUN in mode 2 SHALL decrement the post counter per event and enter DONE on the cycle the event making POST_TRIG post-trigger entries is written.
REQ-010 RUN in mode 1 SHALL enter DONE on the write that makes count == DEPTH.
REQ-011 RUN in modes 0/3 SHALL never leave RUN except by reset.
REQ-012 Write when full without pop, ARMED or RUN mode 0/3: overwrite oldest, advance read pointer, count stays DEPTH, overflow set.
REQ-013 rd_valid SHALL equal (count != 0) in every state; pop on rd_valid && rd_ready, read pointer +1 modulo DEPTH.
REQ-014 Simultaneous write and pop SHALL both take effect, count unchanged, overflow unaffected even when full.
REQ-015 rd_data SHALL be combinational from storage at the read pointer; it changes only on pop, overwrite (REQ-012), or the first write into an empty buffer.
REQ-016 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-017 reset SHALL force state IDLE, count 0, pointers 0, overflow 0, rd_valid 0, post counter 0, latched mode 0, previous-phase register 1; storage contents are not reset.
REQ-018 reset SHALL take priority over arm, capture and pop in the same cycle, including mid-RUN.

Structure
REQ-019 Package nibbler_trace_pkg SHALL hold the state enum, mode enum, widths BYTE_W=8, NIB_W=4, FLAG_W=2, and the entry-width function of ADDR_W.
REQ-020 Storage SHALL be one sub-module nibbler_trace_ram: DEPTH x entry, synchronous write, asynchronous read.

Verification
REQ-021 Reset, arm mode 1, 16 phase rises with address 0..15 -> count 16, DONE, overflow 0; 16 pops return addresses 0..15 in order.
REQ-022 Mode 0, 20 events addresses 0..19, no reads -> count 16, overflow 1, first pop address 4.
REQ-023 Mode 2, trig_addr 0x00A, events addresses 0..30 -> DONE after address 17; buffer holds 2..17; address 0x00A entry present.
REQ-024 Full ring, event coinciding with pop -> count 16, overflow 0, popped entry is previous oldest.
REQ-025 Reset asserted mid-RUN with count 5 -> next cycle IDLE, count 0, rd_valid 0; phase held high through reset release produces no capture.
REQ-026 arm pulsed while RUN in mode 0 -> ignored, count and pointers unchanged.
